// File: rtl/fp_pkg.sv
// fp_pkg: shared binary32 constants, field widths and divider FSM states.
package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_INF = 32'h7F800000;
  localparam logic [31:0] FP_NAN = 32'h7FFFFFFF;
  typedef enum logic [1:0] {IDLE, CALC, NORM, SPEC} state_t;
endpackage

// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: start/busy/done request bus for the sequential divider.
interface fp_div_seq_if;
  logic start;
  logic [31:0] a;
  logic [31:0] b;
  logic busy;
  logic done;
  logic [31:0] result;
  modport master (output start, a, b, input busy, done, result);
  modport slave (input start, a, b, output busy, done, result);
endinterface

// File: rtl/fp_div_classify.sv
// fp_div_classify: classes one binary32 magnitude as zero, inf, NaN or normal.
module fp_div_classify import fp_pkg::*; (
  input  logic [30:0] x,
  output logic zero,
  output logic inf,
  output logic nan,
  output logic norm
);
  logic [FP_EXP_W-1:0] exp_f;
  logic [FP_FRAC_W-1:0] frac_f;
  assign exp_f = x[30:23];
  assign frac_f = x[22:0];
  assign zero = exp_f == '0;
  assign inf = &exp_f && frac_f == '0;
  assign nan = &exp_f && |frac_f;
  assign norm = !zero && !(&exp_f);
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative binary32 divider, one restoring quotient bit per clock.
module fp_div_seq import fp_pkg::*; (
  input logic clk,
  input logic rst,
  fp_div_seq_if.slave bus
);
  state_t state_q, state_d;
  logic [24:0] r_q, r_d, q_q, q_d, rs;
  logic [22:0] mb_q, mb_d, frac;
  logic [4:0] cnt_q, cnt_d;
  logic signed [9:0] e_q, e_d, en;
  logic s_q, s_d, done_q, done_d, s_in, ge;
  logic [31:0] spec_q, spec_d, result_q, result_d, spec_now, norm_res;
  logic za, ia, na, oa, zb, ib, nb, ob;
  fp_div_classify u_ca (.x(bus.a[30:0]), .zero(za), .inf(ia), .nan(na), .norm(oa));
  fp_div_classify u_cb (.x(bus.b[30:0]), .zero(zb), .inf(ib), .nan(nb), .norm(ob));
  always_comb begin
    s_in = bus.a[31] ^ bus.b[31];
    spec_now = (na | nb | (ia & ib) | (za & zb)) ? FP_NAN :
               (ia | zb) ? {s_in, FP_INF[30:0]} : {s_in, 31'd0};
    ge = r_q >= {2'b01, mb_q};
    rs = ge ? r_q - {2'b01, mb_q} : r_q;
    en = q_q[24] ? e_q : e_q - 10'sd1;
    frac = q_q[24] ? q_q[23:1] : q_q[22:0];
    norm_res = (en >= 10'sd255) ? {s_q, FP_INF[30:0]} :
               (en <= 10'sd0) ? {s_q, 31'd0} : {s_q, en[7:0], frac};
    state_d = state_q;
    r_d = r_q;
    q_d = q_q;
    mb_d = mb_q;
    cnt_d = cnt_q;
    e_d = e_q;
    s_d = s_q;
    spec_d = spec_q;
    result_d = result_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        s_d = s_in;
        spec_d = spec_now;
        mb_d = bus.b[22:0];
        r_d = {2'b01, bus.a[22:0]};
        q_d = '0;
        cnt_d = 5'd24;
        e_d = $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + 10'sd127;
        state_d = (oa & ob) ? CALC : SPEC;
      end
      CALC: begin
        r_d = {rs[23:0], 1'b0};
        q_d = {q_q[23:0], ge};
        cnt_d = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd0) ? NORM : CALC;
      end
      NORM: begin
        result_d = norm_res;
        done_d = 1'b1;
        state_d = IDLE;
      end
      SPEC: begin
        result_d = spec_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      q_q <= '0;
      mb_q <= '0;
      cnt_q <= '0;
      e_q <= '0;
      s_q <= 1'b0;
      spec_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      q_q <= q_d;
      mb_q <= mb_d;
      cnt_q <= cnt_d;
      e_q <= e_d;
      s_q <= s_d;
      spec_q <= spec_d;
      result_q <= result_d;
      done_q <= done_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed and randomized checks of fp_div_seq against an arithmetic reference.
module tb_fp_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  fp_div_seq_if dif ();
  fp_div_seq dut (.clk(clk), .rst(rst), .bus(dif.slave));
  always #5 clk = ~clk;

  function automatic logic is_norm(input logic [31:0] x);
    return x[30:23] != 8'd0 && x[30:23] != 8'hFF;
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint unsigned fa, fb, q, frac;
    logic za, zb, ia, ib, na, nb;
    logic [31:0] ev;
    s = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    za = ea == 0; zb = eb == 0;
    ia = ea == 255 && fa == 0; ib = eb == 255 && fb == 0;
    na = ea == 255 && fa != 0; nb = eb == 255 && fb != 0;
    if (na || nb || (ia && ib) || (za && zb)) return 32'h7FFFFFFF;
    if (ia || zb) return {s, 8'hFF, 23'd0};
    if (za || ib) return {s, 31'd0};
    q = ((fa + 64'd8388608) * 64'd16777216) / (fb + 64'd8388608);
    e = ea - eb + 127;
    if (q >= 64'd16777216) frac = (q / 2) % 64'd8388608;
    else begin
      frac = q % 64'd8388608;
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    ev = e;
    return {s, ev[7:0], frac[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    int sel;
    x = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) x[30:23] = 8'd0;
    else if (sel == 1) begin
      x[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 0) x[22:0] = '0;
    end else x[30:23] = 8'($urandom_range(1, 254));
    return x;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output int lat);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = a;
    dif.b = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.a = $urandom;
    dif.b = $urandom;
    lat = 1;
    while (dif.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = dif.result;
  endtask

  task automatic test_reset();
    dif.start = 1'b0;
    dif.a = '0;
    dif.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dif.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", dif.busy); else passed++;
    total++;
    if (dif.done !== 1'b0) $display("FAIL reset_done got=%b want=0", dif.done); else passed++;
    total++;
    if (dif.result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", dif.result); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] da[7] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'hFF800000, 32'h7F000000, 32'h00800000};
    logic [31:0] db[7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h40000000, 32'h3E800000, 32'h40000000};
    logic [31:0] dr[7] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'h7FFFFFFF, 32'hFF800000, 32'h7F800000, 32'h00000000};
    int dl[7] = '{27, 27, 2, 2, 2, 27, 27};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_op(da[i], db[i], res, lat);
      total++;
      if (res !== dr[i]) $display("FAIL directed_result[%0d] %h/%h got=%h want=%h", i, da[i], db[i], res, dr[i]); else passed++;
      total++;
      if (lat != dl[i]) $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, dl[i]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp_r;
    int lat, exp_l;
    for (int i = 0; i < 40; i++) begin
      a = rand_op();
      b = rand_op();
      exp_r = ref_div(a, b);
      exp_l = (is_norm(a) && is_norm(b)) ? 27 : 2;
      run_op(a, b, res, lat);
      total++;
      if (res !== exp_r) $display("FAIL random_result %h/%h got=%h want=%h", a, b, res, exp_r); else passed++;
      total++;
      if (lat != exp_l) $display("FAIL random_latency %h/%h got=%0d want=%0d", a, b, lat, exp_l); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2;
    run_op(32'h3F800000, 32'h40400000, r1, l1);
    run_op(32'h40C00000, 32'h40000000, r2, l2);
    total++;
    if (r1 !== 32'h3EAAAAAA || r2 !== 32'h40400000) $display("FAIL b2b_results got=%h,%h want=3eaaaaaa,40400000", r1, r2); else passed++;
    total++;
    if (l2 != 27) $display("FAIL b2b_latency got=%0d want=27", l2); else passed++;
  endtask

  task automatic test_busy_collision();
    int n, dones, first_lat;
    logic [31:0] res;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = 32'h40C00000;
    dif.b = 32'h40000000;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    n = 1;
    dones = 0;
    first_lat = 0;
    res = '0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) begin
        dif.start = 1'b1;
        dif.a = 32'h3F800000;
        dif.b = 32'h40400000;
      end else dif.start = 1'b0;
      if (dif.done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          first_lat = n;
          res = dif.result;
        end
      end
    end
    total++;
    if (res !== 32'h40400000) $display("FAIL collision_result got=%h want=40400000", res); else passed++;
    total++;
    if (first_lat != 27) $display("FAIL collision_latency got=%0d want=27", first_lat); else passed++;
    total++;
    if (dones != 1) $display("FAIL collision_done_count got=%0d want=1", dones); else passed++;
  endtask

  task automatic test_reset_mid();
    int n, dones, lat;
    logic [31:0] res;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = 32'h3F800000;
    dif.b = 32'h40400000;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    for (n = 1; n < 12; n++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) $display("FAIL midreset_busy_done got=%b%b want=00", dif.busy, dif.done); else passed++;
    total++;
    if (dif.result !== 32'h0) $display("FAIL midreset_result got=%h want=00000000", dif.result); else passed++;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (dif.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) $display("FAIL midreset_spurious_done got=%0d want=0", dones); else passed++;
    run_op(32'h40C00000, 32'h40000000, res, lat);
    total++;
    if (res !== 32'h40400000 || lat != 27) $display("FAIL midreset_fresh got=%h lat=%0d want=40400000 lat=27", res, lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
